// File: rtl/core_pkg.sv
// Shared definitions for the multicycle RV64 core: widths, fetch FSM encoding
// and instruction constants.
package core_pkg;

  localparam int unsigned XLEN = 64;

  localparam int unsigned INST_BYTES = 4;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues level req/ready fetches, latches the IR and
// discards any response still in flight when a redirect arrives.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] seq_pc;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign seq_pc       = req_addr_q + XLEN'(INST_BYTES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ir_q       <= NOP_INST;
      inst_pc_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ir_q       <= ir_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  // Redirect outranks the memory response, which outranks the decode handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ir_d       = ir_q;
    inst_pc_d  = inst_pc_q;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (mem_ready) begin
            req_addr_d = redirect_tgt;
          end else begin
            state_d = DROP;
          end
        end else if (mem_ready) begin
          ir_d      = mem_rdata;
          inst_pc_d = req_addr_q;
          pc_d      = seq_pc;
          state_d   = FULL;
        end
      end
      FULL: begin
        if (redirect_valid) begin
          pc_d       = redirect_tgt;
          req_addr_d = redirect_tgt;
          state_d    = FETCH;
        end else if (inst_ready) begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end
      DROP: begin
        // The old request stays on the bus until memory answers; a redirect in
        // the answering cycle still wins as the next fetch address.
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end
        if (mem_ready) begin
          req_addr_d = redirect_valid ? redirect_tgt : pc_q;
          state_d    = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    inst_valid = 1'b0;
    unique case (state_q)
      FETCH:   mem_req    = 1'b1;
      DROP:    mem_req    = 1'b1;
      FULL:    inst_valid = 1'b1;
      default: mem_req    = 1'b0;
    endcase
  end

  assign mem_addr = req_addr_q;
  assign inst     = ir_q;
  assign inst_pc  = inst_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: latency-programmable memory model,
// scoreboard of expected instruction order checked on each decode handshake.
module tb_instr_fetch_unit;

  localparam logic [63:0] RPC = 64'h100;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  int wait_cnt;
  logic [63:0] exp_q[$];

  instr_fetch_unit #(.XLEN(64), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    if (a == 64'h100) return 32'hFFF00093;
    return a[31:0] ^ 32'h5A5A0000;
  endfunction

  // Memory: answers after lat idle cycles of a held request.
  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign mem_ready = mem_req && (wait_cnt >= lat);
  assign mem_rdata = word(mem_addr);

  // Scoreboard: every accepted decode handshake must match the next expected PC.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got inst_pc=%h expected none", inst_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (inst_pc !== e || inst !== word(e)) begin
          failures++;
          $display("FAIL sb_order got pc=%h inst=%h expected pc=%h inst=%h",
                   inst_pc, inst, e, word(e));
        end
      end
    end
  end

  // Address must stay put while a request waits for memory.
  logic        prev_req, prev_rdy, prev_rst;
  logic [63:0] prev_addr;
  always @(negedge clk) begin
    if (!reset && !prev_rst && prev_req && !prev_rdy && mem_req) begin
      checks++;
      if (mem_addr !== prev_addr) begin
        failures++;
        $display("FAIL addr_stable got %h expected %h", mem_addr, prev_addr);
      end
    end
    prev_req  = mem_req;
    prev_rdy  = mem_ready;
    prev_rst  = reset;
    prev_addr = mem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 40) begin tick(); n++; end
    checks++;
    if (!inst_valid) begin
      failures++;
      $display("FAIL %s_timeout got inst_valid=0 expected 1", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin tick(); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect_to(input logic [63:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_addr, inst, inst_pc, inst_valid} !== {1'b1, RPC, NOP, 64'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_vals got req=%b addr=%h inst=%h pc=%h v=%b expected 1 %h %h 0 0",
               mem_req, mem_addr, inst, inst_pc, inst_valid, RPC, NOP);
    end
    reset = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RPC) begin
      failures++;
      $display("FAIL first_req got req=%b addr=%h expected 1 %h", mem_req, mem_addr, RPC);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hFFF00093 || inst_pc !== RPC || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL first_inst got v=%b inst=%h pc=%h req=%b expected 1 fff00093 %h 0",
               inst_valid, inst, inst_pc, mem_req, RPC);
    end
    exp_q.push_back(RPC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (mem_addr !== 64'h104 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL next_addr got addr=%h v=%b expected 104 0", mem_addr, inst_valid);
    end
  endtask

  task automatic test_latency();
    wait_valid("lat_pre");
    lat = 2;
    redirect_to(64'h0);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin
        failures++;
        $display("FAIL lat_hold%0d got req=%b addr=%h expected 1 0", k, mem_req, mem_addr);
      end
      tick();
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h0) begin
      failures++;
      $display("FAIL lat_first got v=%b pc=%h expected 1 0", inst_valid, inst_pc);
    end
    wait_drain("lat");
    inst_ready = 1'b0;
  endtask

  task automatic test_stall();
    wait_valid("stall_pre");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 64'hC || inst !== word(64'hC)) begin
        failures++;
        $display("FAIL stall%0d got req=%b v=%b pc=%h inst=%h expected 0 1 c %h",
                 i, mem_req, inst_valid, inst_pc, inst, word(64'hC));
      end
      tick();
    end
    exp_q.push_back(64'hC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h10) begin
      failures++;
      $display("FAIL stall_release got req=%b addr=%h expected 1 10", mem_req, mem_addr);
    end
  endtask

  task automatic test_drop();
    lat = 1;
    wait_valid("drop_pre");
    redirect_to(64'h8);
    checks++;
    if (mem_addr !== 64'h8 || mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL drop_pend got addr=%h rdy=%b expected 8 0", mem_addr, mem_ready);
    end
    redirect_to(64'h203);
    checks++;
    if (mem_addr !== 64'h8 || mem_req !== 1'b1 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_hold got addr=%h req=%b v=%b expected 8 1 0", mem_addr, mem_req, inst_valid);
    end
    tick();
    checks++;
    if (mem_addr !== 64'h200 || mem_req !== 1'b1 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_target got addr=%h req=%b v=%b expected 200 1 0", mem_addr, mem_req, inst_valid);
    end
    exp_q.push_back(64'h200);
    inst_ready = 1'b1;
    wait_drain("drop");
    inst_ready = 1'b0;
  endtask

  task automatic test_coincident();
    lat = 0;
    wait_valid("coin_pre");
    redirect_to(64'h300);
    checks++;
    if (mem_addr !== 64'h300 || mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL coin_fetch got addr=%h rdy=%b expected 300 1", mem_addr, mem_ready);
    end
    redirect_to(64'h400);
    checks++;
    if (mem_addr !== 64'h400 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL coin_resp_drop got addr=%h v=%b expected 400 0", mem_addr, inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h400 || inst !== word(64'h400)) begin
      failures++;
      $display("FAIL coin_target got v=%b pc=%h inst=%h expected 1 400 %h",
               inst_valid, inst_pc, inst, word(64'h400));
    end
    exp_q.push_back(64'h400);
    inst_ready = 1'b1;
    redirect_to(64'h500);
    inst_ready = 1'b0;
    checks++;
    if (mem_addr !== 64'h500 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL coin_hs got addr=%h v=%b expected 500 0", mem_addr, inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h500) begin
      failures++;
      $display("FAIL coin_hs_next got v=%b pc=%h expected 1 500", inst_valid, inst_pc);
    end
  endtask

  task automatic test_wrap();
    redirect_to('1);
    checks++;
    if (mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_align got %h expected fffffffffffffffc", mem_addr);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_inst got v=%b pc=%h expected 1 fffffffffffffffc", inst_valid, inst_pc);
    end
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    lat = 3;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin
      failures++;
      $display("FAIL wrap_next got req=%b addr=%h expected 1 0", mem_req, mem_addr);
    end
  endtask

  task automatic test_async_reset();
    redirect_to(64'h700);
    checks++;
    if (mem_addr !== 64'h0 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL ar_drop got addr=%h req=%b expected 0 1", mem_addr, mem_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_addr, inst, inst_pc, inst_valid} !== {1'b1, RPC, NOP, 64'h0, 1'b0}) begin
      failures++;
      $display("FAIL ar_vals got req=%b addr=%h inst=%h pc=%h v=%b expected 1 %h %h 0 0",
               mem_req, mem_addr, inst, inst_pc, inst_valid, RPC, NOP);
    end
    tick();
    lat   = 0;
    reset = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== RPC) begin
      failures++;
      $display("FAIL ar_refetch got v=%b pc=%h expected 1 %h", inst_valid, inst_pc, RPC);
    end
  endtask

  initial begin
    reset          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_latency();
    test_stall();
    test_drop();
    test_coincident();
    test_wrap();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
